rv32_exec_stage: RTL and testbench
==================================

Name: rv32_exec_stage

Overview:
- Execute stage directly downstream of the register-file read/issue stage.
- Consumes an issued operation: rs1/rs2 operand values, 32-bit immediate, ALU opcode and destination register.
- Computes the result and drives the writeback bus (wb_en, wb_sel, wb_data) that returns to the register file.
- Single-cycle ALU ops take 1 cycle; MUL/DIVU/REMU use an iterative 32-step unit and stall issue via a ready handshake.

Parameters:
- OP_W, 4, alu_op field width.
- ENABLE_MULDIV, 1, 0 = MUL/DIVU/REMU treated as illegal (result 0, wb suppressed).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  issued op present this cycle.
- issue_ready  out  1  stage can accept an op this cycle.
- rs1_value  in  32  operand A.
- rs2_value  in  32  operand B (register).
- imm32  in  32  immediate.
- use_imm  in  1  1 = operand B is imm32, 0 = rs2_value.
- alu_op  in  OP_W  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 DIVU, 12 REMU, 13-15 illegal.
- rd_sel  in  5  destination register.
- flush  in  1  kill in-flight op, no writeback.
- wb_en  out  1  one-cycle write strobe to the register file.
- wb_sel  out  5  destination register.
- wb_data  out  32  result.
- busy  out  1  iterative unit active.

Behaviour:
- Reset (async, reset=1): state IDLE; wb_en=0, wb_sel=0, wb_data=0, busy=0, issue_ready=1; counter and partial registers cleared. Reset mid-iteration abandons the op with no writeback.
- Handshake: op accepted on a rising edge when issue_valid && issue_ready. issue_ready = (state==IDLE) && !flush.
- Operand B = use_imm ? imm32 : rs2_value.
- Shifts use B[4:0] only. SRA is arithmetic. SLT is signed compare, SLTU unsigned; result is 0 or 1.
- All arithmetic is mod 2^32, with no overflow flag.
- Single-cycle ops: accept at edge N; wb_en=1 with result during cycle N+1 (registered); stage stays IDLE, so back-to-back ops are accepted every cycle.
- States: IDLE, MUL_RUN, DIV_RUN, DONE.
- IDLE -> MUL_RUN on accepted MUL. Shift-add over 32 steps, keeping low 32 bits of the product.
- IDLE -> DIV_RUN on accepted DIVU/REMU. Restoring division over 32 steps, unsigned.
- Step counter 0..31. After the step with counter==31 -> DONE. DONE drives wb_en=1 for exactly one cycle, then -> IDLE.
- Latency: accept at N -> wb_en during cycle N+33. busy=1 in MUL_RUN/DIV_RUN/DONE; issue_ready=0 throughout.
- DIVU/REMU by zero: no iteration. Result at N+1 like a single-cycle op: DIVU -> 0xFFFFFFFF, REMU -> rs1_value.
- wb_sel = rd_sel captured at accept. wb_en is forced 0 when the captured rd==0 (result still computed, state sequence unchanged).
- Illegal opcode (or MUL/DIV with ENABLE_MULDIV=0): accepted, no writeback, wb_data=0.
- flush=1: state -> IDLE next edge, counter cleared. Any wb_en that would fire next cycle is suppressed, and an op presented in the same cycle is not accepted. flush in IDLE with no op is a no-op.
- wb_data/wb_sel hold their last value when wb_en=0.
- Simultaneous reset and flush: reset wins.

Test Plan:
- ADD rs1=0x7FFFFFFF, rs2=1, use_imm=0, rd=5 -> next cycle wb_en=1, wb_sel=5, wb_data=0x80000000. Back-to-back SUB 3-5 (use_imm=1, imm=5) -> 0xFFFFFFFE the following cycle.
- SRA rs1=0x80000000, B=0x00000024 (shamt 4) -> 0xF8000000. SRL on the same operands -> 0x08000000. SLT(-1,1)=1, SLTU(0xFFFFFFFF,1)=0.
- MUL 0x00012345 * 0x00010000, accepted at cycle 10 -> issue_ready=0 for cycles 11-43, wb_en only in cycle 43 with wb_data=0x23450000.
- DIVU 100/7 -> 14; REMU 100/7 -> 2, each at +33 cycles. DIVU x/0 -> 0xFFFFFFFF at +1; REMU 9/0 -> 9 at +1.
- MUL started, flush asserted at step 10 -> no wb_en ever for that op; issue_ready=1 the cycle after flush; next ADD completes normally.
- ADD with rd=0 -> wb_en stays 0. reset pulsed during DIV_RUN -> all outputs 0 immediately (async), issue_ready=1, no later writeback.

Source files
------------

// File: rtl/rv32_exec_stage_if.sv
// Issue and writeback bundle between the issue stage, the execute stage and the register file.
// The issue side is the master; the execute stage is the slave.
interface rv32_exec_stage_if #(
    parameter int OP_W = 4
);
    logic            issue_valid;
    logic            issue_ready;
    logic [31:0]     rs1_value;
    logic [31:0]     rs2_value;
    logic [31:0]     imm32;
    logic            use_imm;
    logic [OP_W-1:0] alu_op;
    logic [4:0]      rd_sel;
    logic            flush;
    logic            wb_en;
    logic [4:0]      wb_sel;
    logic [31:0]     wb_data;
    logic            busy;

    modport master (
        output issue_valid, rs1_value, rs2_value, imm32, use_imm, alu_op, rd_sel, flush,
        input  issue_ready, wb_en, wb_sel, wb_data, busy
    );

    modport slave (
        input  issue_valid, rs1_value, rs2_value, imm32, use_imm, alu_op, rd_sel, flush,
        output issue_ready, wb_en, wb_sel, wb_data, busy
    );
endinterface

// File: rtl/rv32_exec_stage.sv
// RV32 execute stage: single-cycle ALU plus a shared 32-step shift-add multiplier / restoring divider.
// Results return to the register file through a registered one-cycle writeback strobe.
module rv32_exec_stage #(
    parameter int OP_W          = 4,
    parameter bit ENABLE_MULDIV = 1'b1
) (
    input logic              clk,
    input logic              reset,
    rv32_exec_stage_if.slave bus
);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SLTU = OP_W'(9);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_DIVU = OP_W'(11);
    localparam logic [OP_W-1:0] OP_REMU = OP_W'(12);

    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] op_a;      // multiplicand (MUL) or divisor (DIV)
    logic [31:0] op_b;      // multiplier (MUL) or dividend shifting into quotient (DIV)
    logic [31:0] acc;       // partial product (MUL) or partial remainder (DIV)
    logic        is_rem_q;
    logic [4:0]  rd_q;

    logic [31:0] opb;
    logic [4:0]  shamt;
    logic [31:0] single_res;
    logic        single_ok;
    logic        start_mul;
    logic        start_div;
    logic [31:0] mul_acc_nx;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [31:0] div_rem_nx;
    logic [31:0] div_q_nx;
    logic [31:0] run_res;

    assign bus.issue_ready = (state == IDLE) && !bus.flush;
    assign bus.busy        = (state != IDLE);

    always_comb begin
        opb        = bus.use_imm ? bus.imm32 : bus.rs2_value;
        shamt      = opb[4:0];
        single_ok  = 1'b1;
        single_res = '0;
        case (bus.alu_op)
            OP_ADD:  single_res = bus.rs1_value + opb;
            OP_SUB:  single_res = bus.rs1_value - opb;
            OP_AND:  single_res = bus.rs1_value & opb;
            OP_OR:   single_res = bus.rs1_value | opb;
            OP_XOR:  single_res = bus.rs1_value ^ opb;
            OP_SLL:  single_res = bus.rs1_value << shamt;
            OP_SRL:  single_res = bus.rs1_value >> shamt;
            OP_SRA:  single_res = 32'($signed(bus.rs1_value) >>> shamt);
            OP_SLT:  single_res = {31'd0, $signed(bus.rs1_value) < $signed(opb)};
            OP_SLTU: single_res = {31'd0, bus.rs1_value < opb};
            // Division by zero never enters the iterative unit; it completes like an ALU op.
            OP_DIVU: begin
                single_ok  = ENABLE_MULDIV && (opb == 32'd0);
                single_res = 32'hFFFF_FFFF;
            end
            OP_REMU: begin
                single_ok  = ENABLE_MULDIV && (opb == 32'd0);
                single_res = bus.rs1_value;
            end
            default: single_ok = 1'b0;
        endcase
        start_mul = ENABLE_MULDIV && (bus.alu_op == OP_MUL);
        start_div = ENABLE_MULDIV && ((bus.alu_op == OP_DIVU) || (bus.alu_op == OP_REMU))
                    && (opb != 32'd0);
    end

    always_comb begin
        mul_acc_nx = acc + (op_b[0] ? op_a : 32'd0);
        div_shift  = {acc, op_b[31]};
        div_diff   = div_shift - {1'b0, op_a};
        div_rem_nx = div_diff[32] ? div_shift[31:0] : div_diff[31:0];
        div_q_nx   = {op_b[30:0], ~div_diff[32]};
        if (state == MUL_RUN) begin
            run_res = mul_acc_nx;
        end else begin
            run_res = is_rem_q ? div_rem_nx : div_q_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            op_a        <= '0;
            op_b        <= '0;
            acc         <= '0;
            is_rem_q    <= 1'b0;
            rd_q        <= '0;
            bus.wb_en   <= 1'b0;
            bus.wb_sel  <= '0;
            bus.wb_data <= '0;
        end else if (bus.flush) begin
            state     <= IDLE;
            cnt       <= '0;
            bus.wb_en <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.wb_en <= 1'b0;
                    if (bus.issue_valid) begin
                        rd_q <= bus.rd_sel;
                        cnt  <= '0;
                        if (start_mul) begin
                            acc   <= '0;
                            op_a  <= bus.rs1_value;
                            op_b  <= opb;
                            state <= MUL_RUN;
                        end else if (start_div) begin
                            acc      <= '0;
                            op_a     <= opb;
                            op_b     <= bus.rs1_value;
                            is_rem_q <= (bus.alu_op == OP_REMU);
                            state    <= DIV_RUN;
                        end else if (single_ok) begin
                            if (bus.rd_sel != 5'd0) begin
                                bus.wb_en   <= 1'b1;
                                bus.wb_sel  <= bus.rd_sel;
                                bus.wb_data <= single_res;
                            end
                        end else begin
                            bus.wb_data <= '0;
                        end
                    end
                end
                MUL_RUN, DIV_RUN: begin
                    cnt <= cnt + 5'd1;
                    if (state == MUL_RUN) begin
                        acc  <= mul_acc_nx;
                        op_a <= op_a << 1;
                        op_b <= op_b >> 1;
                    end else begin
                        acc  <= div_rem_nx;
                        op_b <= div_q_nx;
                    end
                    if (cnt == 5'd31) begin
                        state <= DONE;
                        if (rd_q != 5'd0) begin
                            bus.wb_en   <= 1'b1;
                            bus.wb_sel  <= rd_q;
                            bus.wb_data <= run_res;
                        end
                    end
                end
                DONE: begin
                    bus.wb_en <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32_exec_stage.sv
// Scoreboard bench for rv32_exec_stage: expected writebacks (cycle, rd, data) are queued at issue
// and matched against every wb_en strobe; scenario tasks add inline handshake/state checks.
module tb_rv32_exec_stage;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        int          cyc;
        logic [4:0]  sel;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    rv32_exec_stage_if #(.OP_W(4)) bus ();

    rv32_exec_stage #(.OP_W(4), .ENABLE_MULDIV(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << b[4:0];
            4'd6:  r = a >> b[4:0];
            4'd7:  r = $signed(a) >>> b[4:0];
            4'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  r = (a < b) ? 32'd1 : 32'd0;
            4'd10: r = a * b;
            4'd11: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            4'd12: r = (b == 32'd0) ? a : a % b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset && bus.wb_en) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_wb cyc=%0d got sel=%0d data=%h required no writeback", cyc, bus.wb_sel, bus.wb_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (cyc !== e.cyc) begin
                    failures++;
                    $display("FAIL wb_cycle got=%0d required=%0d", cyc, e.cyc);
                end
                checks++;
                if (bus.wb_sel !== e.sel) begin
                    failures++;
                    $display("FAIL wb_sel got=%0d required=%0d", bus.wb_sel, e.sel);
                end
                checks++;
                if (bus.wb_data !== e.data) begin
                    failures++;
                    $display("FAIL wb_data got=%h required=%h", bus.wb_data, e.data);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic ui, input logic [4:0] rd, input bit expect_wb);
        int n;
        logic [31:0] bop;
        int lat;
        n = 0;
        while (!bus.issue_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout got issue_ready=%b required 1 within 100 cycles", bus.issue_ready);
        end
        bop = ui ? imm : b;
        lat = (op == 4'd10 || ((op == 4'd11 || op == 4'd12) && bop != 32'd0)) ? 32 : 0;
        bus.alu_op      = op;
        bus.rs1_value   = a;
        bus.rs2_value   = b;
        bus.imm32       = imm;
        bus.use_imm     = ui;
        bus.rd_sel      = rd;
        bus.issue_valid = 1'b1;
        if (expect_wb && rd != 5'd0 && op <= 4'd12)
            sb.push_back('{cyc + 1 + lat, rd, model(op, a, bop)});
        @(posedge clk);
        #1;
        bus.issue_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.wb_en, bus.wb_sel, bus.wb_data, bus.busy, bus.issue_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state got en=%b sel=%0d data=%h busy=%b ready=%b required 0/0/0/0/1",
                     bus.wb_en, bus.wb_sel, bus.wb_data, bus.busy, bus.issue_ready);
        end
    endtask

    task automatic test_back_to_back();
        issue(4'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd5, 1'b1);
        issue(4'd1, 32'd3, 32'd0, 32'd5, 1'b1, 5'd6, 1'b1);
        issue(4'd7, 32'h8000_0000, 32'd0, 32'h24, 1'b1, 5'd7, 1'b1);
        issue(4'd6, 32'h8000_0000, 32'h24, 32'd0, 1'b0, 5'd8, 1'b1);
        issue(4'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd9, 1'b1);
        issue(4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd10, 1'b1);
        issue(4'd5, 32'h0000_0003, 32'h21, 32'd0, 1'b0, 5'd11, 1'b1);
    endtask

    task automatic test_mul();
        issue(4'd10, 32'h0001_2345, 32'h0001_0000, 32'd0, 1'b0, 5'd12, 1'b1);
        for (int i = 0; i < 33; i++) begin
            checks++;
            if (bus.issue_ready !== 1'b0 || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL mul_stall step=%0d got ready=%b busy=%b required 0/1", i, bus.issue_ready, bus.busy);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (bus.issue_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL mul_release got ready=%b busy=%b required 1/0", bus.issue_ready, bus.busy);
        end
    endtask

    task automatic test_div();
        issue(4'd11, 32'd100, 32'd7, 32'd0, 1'b0, 5'd13, 1'b1);
        issue(4'd12, 32'd100, 32'd7, 32'd0, 1'b0, 5'd14, 1'b1);
        issue(4'd11, 32'h1234_5678, 32'd0, 32'd0, 1'b0, 5'd15, 1'b1);
        issue(4'd12, 32'd9, 32'd0, 32'd0, 1'b1, 5'd16, 1'b1);
        issue(4'd11, 32'hFFFF_FFFF, 32'd0, 32'h0000_0003, 1'b1, 5'd17, 1'b1);
    endtask

    task automatic test_flush();
        issue(4'd10, 32'hDEAD_BEEF, 32'h0000_1234, 32'd0, 1'b0, 5'd18, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready_low got=%b required=0", bus.issue_ready);
        end
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        #1;
        checks++;
        if (bus.issue_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle got ready=%b busy=%b required 1/0", bus.issue_ready, bus.busy);
        end
        // op presented together with flush must be dropped
        bus.alu_op = 4'd0; bus.rs1_value = 32'd1; bus.rs2_value = 32'd1; bus.use_imm = 1'b0;
        bus.rd_sel = 5'd19; bus.issue_valid = 1'b1; bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.issue_valid = 1'b0;
        bus.flush = 1'b0;
        checks++;
        if (bus.wb_en !== 1'b0) begin
            failures++;
            $display("FAIL flush_same_cycle got wb_en=%b required=0", bus.wb_en);
        end
        issue(4'd0, 32'd40, 32'd2, 32'd0, 1'b0, 5'd20, 1'b1);
    endtask

    task automatic test_rd0_illegal();
        issue(4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 5'd0, 1'b1);
        checks++;
        if (bus.wb_en !== 1'b0) begin
            failures++;
            $display("FAIL rd0_wb_en got=%b required=0", bus.wb_en);
        end
        issue(4'd13, 32'd5, 32'd6, 32'd0, 1'b0, 5'd3, 1'b1);
        checks++;
        if (bus.wb_en !== 1'b0 || bus.wb_data !== 32'd0) begin
            failures++;
            $display("FAIL illegal_op got en=%b data=%h required 0/00000000", bus.wb_en, bus.wb_data);
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(0, 12));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
            issue(op, a, b, b, 1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)), 1'b1);
        end
    endtask

    task automatic test_reset_mid_div();
        issue(4'd11, 32'd1000, 32'd3, 32'd0, 1'b0, 5'd21, 1'b0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.wb_en, bus.wb_sel, bus.wb_data, bus.busy, bus.issue_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid_div got en=%b sel=%0d data=%h busy=%b ready=%b required 0/0/0/0/1",
                     bus.wb_en, bus.wb_sel, bus.wb_data, bus.busy, bus.issue_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.issue_valid = 1'b0;
        bus.rs1_value = '0;
        bus.rs2_value = '0;
        bus.imm32 = '0;
        bus.use_imm = 1'b0;
        bus.alu_op = '0;
        bus.rd_sel = '0;
        bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_mul();
        test_div();
        test_flush();
        test_rd0_illegal();
        test_random();
        test_reset_mid_div();
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL missing_wb got pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
